// File: rtl/utf8_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : utf8_decoder_if
// Brief    : Byte-in / code-point-out handshake bundle for utf8_decoder.
//            slave  = decoder side, master = byte source + code-point sink.
// Revision : 1.0  initial release
// ============================================================================
interface utf8_decoder_if;
    logic [7:0]  in_data;
    logic        in_data_available;
    logic        in_data_ready;
    logic [20:0] out_codepoint;
    logic        out_available;
    logic        receiver_ready;

    modport slave (
        input  in_data,
        input  in_data_available,
        output in_data_ready,
        output out_codepoint,
        output out_available,
        input  receiver_ready
    );

    modport master (
        output in_data,
        output in_data_available,
        input  in_data_ready,
        input  out_codepoint,
        input  out_available,
        output receiver_ready
    );
endinterface
`default_nettype wire

// File: rtl/utf8_decoder.sv
`default_nettype none
// ============================================================================
// Module   : utf8_decoder
// Brief    : Streaming UTF-8 to Unicode code point decoder with strict
//            validation; each maximal malformed subpart becomes
//            REPLACEMENT_CHAR. One registered output slot.
// Revision : 1.0  initial release
// ============================================================================
module utf8_decoder #(
    parameter logic [20:0] REPLACEMENT_CHAR = 21'h00FFFD
) (
    input  logic          clk,
    input  logic          reset,
    utf8_decoder_if.slave bus
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_cont    = 2'd1;
    localparam logic [1:0] c_st_pending = 2'd2;

    logic [1:0]  r_state;
    logic [14:0] r_acc;       // partial code point, at most 15 bits before the final byte
    logic [1:0]  r_need;      // continuation bytes still expected
    logic [7:0]  r_lead;      // lead byte, needed for first-continuation range limits
    logic        r_first;     // next continuation byte is the first one
    logic [7:0]  r_pending;   // rejected byte awaiting reprocessing as a lead
    logic [20:0] r_codepoint;
    logic        r_avail;

    logic        w_slot_free;
    logic        w_accept;
    logic        w_go;
    logic [7:0]  w_byte;
    logic        w_cont_ok;
    logic [20:0] w_shift;
    logic        w_emit;
    logic [20:0] w_value;
    logic [1:0]  w_next_state;
    logic [14:0] w_next_acc;
    logic [1:0]  w_next_need;
    logic [7:0]  w_next_lead;
    logic        w_next_first;
    logic [7:0]  w_next_pending;

    assign w_slot_free       = ~r_avail | bus.receiver_ready;
    assign bus.in_data_ready = w_slot_free & (r_state != c_st_pending);
    assign w_accept          = bus.in_data_available & bus.in_data_ready;
    assign bus.out_codepoint = r_codepoint;
    assign bus.out_available = r_avail;

    // A held byte is replayed as soon as the output slot can take its result.
    assign w_go   = (r_state == c_st_pending) ? w_slot_free : w_accept;
    assign w_byte = (r_state == c_st_pending) ? r_pending : bus.in_data;
    assign w_shift = {r_acc, w_byte[5:0]};

    // Continuation byte check, with tightened ranges after E0/ED/F0/F4 that
    // exclude overlongs, surrogates and code points above 10FFFF.
    always_comb begin
        w_cont_ok = (w_byte[7:6] == 2'b10);
        if (r_first) begin
            case (r_lead)
                8'hE0:   w_cont_ok = w_cont_ok & (w_byte >= 8'hA0);
                8'hED:   w_cont_ok = w_cont_ok & (w_byte <= 8'h9F);
                8'hF0:   w_cont_ok = w_cont_ok & (w_byte >= 8'h90);
                8'hF4:   w_cont_ok = w_cont_ok & (w_byte <= 8'h8F);
                default: w_cont_ok = w_cont_ok;
            endcase
        end
    end

    // Next-state decode: lead-byte classification in IDLE/PENDING,
    // accumulation or rejection in CONT.
    always_comb begin
        w_emit         = 1'b0;
        w_value        = 21'd0;
        w_next_state   = r_state;
        w_next_acc     = r_acc;
        w_next_need    = r_need;
        w_next_lead    = r_lead;
        w_next_first   = r_first;
        w_next_pending = r_pending;
        if (w_go) begin
            if (r_state == c_st_cont) begin
                if (w_cont_ok) begin
                    w_next_acc   = w_shift[14:0];
                    w_next_need  = r_need - 2'd1;
                    w_next_first = 1'b0;
                    if (r_need == 2'd1) begin
                        w_emit       = 1'b1;
                        w_value      = w_shift;
                        w_next_state = c_st_idle;
                    end
                end else begin
                    w_emit         = 1'b1;
                    w_value        = REPLACEMENT_CHAR;
                    w_next_pending = w_byte;
                    w_next_state   = c_st_pending;
                end
            end else begin
                w_next_lead  = w_byte;
                w_next_first = 1'b1;
                w_next_state = c_st_idle;
                if (w_byte <= 8'h7F) begin
                    w_emit  = 1'b1;
                    w_value = {13'd0, w_byte};
                end else if (w_byte >= 8'hC2 && w_byte <= 8'hDF) begin
                    w_next_acc   = {10'd0, w_byte[4:0]};
                    w_next_need  = 2'd1;
                    w_next_state = c_st_cont;
                end else if (w_byte >= 8'hE0 && w_byte <= 8'hEF) begin
                    w_next_acc   = {11'd0, w_byte[3:0]};
                    w_next_need  = 2'd2;
                    w_next_state = c_st_cont;
                end else if (w_byte >= 8'hF0 && w_byte <= 8'hF4) begin
                    w_next_acc   = {12'd0, w_byte[2:0]};
                    w_next_need  = 2'd3;
                    w_next_state = c_st_cont;
                end else begin
                    w_emit  = 1'b1;
                    w_value = REPLACEMENT_CHAR;
                end
            end
        end
    end

    // Decoder state registers; reset discards any partial sequence silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_acc     <= 15'd0;
            r_need    <= 2'd0;
            r_lead    <= 8'd0;
            r_first   <= 1'b0;
            r_pending <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_acc     <= w_next_acc;
            r_need    <= w_next_need;
            r_lead    <= w_next_lead;
            r_first   <= w_next_first;
            r_pending <= w_next_pending;
        end
    end

    // Output slot: refill on emit (also covers consume+emit in one cycle),
    // otherwise drain when the receiver takes the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_codepoint <= 21'd0;
            r_avail     <= 1'b0;
        end else if (w_emit) begin
            r_codepoint <= w_value;
            r_avail     <= 1'b1;
        end else if (bus.receiver_ready) begin
            r_avail     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_utf8_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_utf8_decoder
// Brief    : Directed self-checking bench for utf8_decoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_utf8_decoder;

    logic clk;
    logic reset;
    utf8_decoder_if bus ();

    utf8_decoder #(.REPLACEMENT_CHAR(21'h00FFFD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [20:0] got[$];

    // Collect every transferred word; inputs only change 2 ns after posedge.
    always @(negedge clk) begin
        if (!reset && bus.out_available && bus.receiver_ready)
            got.push_back(bus.out_codepoint);
    end

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input string tag, input logic [7:0] b);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.in_data           = b;
        bus.in_data_available = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_data_ready;
            step();
            n++;
        end
        bus.in_data_available = 1'b0;
        if (!acc) chk({tag, "_accept_timeout"}, 21'd0, 21'd1);
    endtask

    task automatic check_outs(input string tag, input int n,
                              input logic [20:0] e0, input logic [20:0] e1,
                              input logic [20:0] e2);
        logic [20:0] exp_v[3];
        exp_v[0] = e0;
        exp_v[1] = e1;
        exp_v[2] = e2;
        repeat (4) step();
        chk({tag, "_count"}, 21'(got.size()), 21'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk($sformatf("%s_out%0d", tag, i), got[i], exp_v[i]);
            else                chk($sformatf("%s_out%0d_missing", tag, i), 21'h1FFFFF, exp_v[i]);
        end
        got.delete();
    endtask

    initial begin
        reset                 = 1'b1;
        bus.in_data           = 8'h00;
        bus.in_data_available = 1'b0;
        bus.receiver_ready    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_codepoint", bus.out_codepoint, 21'd0);
        chk("rst_available", 21'(bus.out_available), 21'd0);
        chk("rst_in_ready", 21'(bus.in_data_ready), 21'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        step();

        // ASCII with one-cycle latency
        send("ascii", 8'h41);
        chk("ascii_lat_avail", 21'(bus.out_available), 21'd1);
        chk("ascii_lat_value", bus.out_codepoint, 21'h000041);
        check_outs("ascii", 1, 21'h000041, 21'd0, 21'd0);

        // Multi-byte sequences
        send("c3", 8'hC3); send("a9", 8'hA9);
        check_outs("two_byte", 1, 21'h0000E9, 21'd0, 21'd0);
        send("e2", 8'hE2); send("82", 8'h82); send("ac", 8'hAC);
        check_outs("three_byte", 1, 21'h0020AC, 21'd0, 21'd0);
        send("f0", 8'hF0); send("9f", 8'h9F); send("98", 8'h98); send("80", 8'h80);
        check_outs("four_byte", 1, 21'h01F600, 21'd0, 21'd0);

        // Truncated sequence: rejected byte is held, input stalls one cycle
        send("c3", 8'hC3); send("41", 8'h41);
        chk("pending_in_ready", 21'(bus.in_data_ready), 21'd0);
        chk("pending_first_out", bus.out_codepoint, 21'h00FFFD);
        check_outs("truncated", 2, 21'h00FFFD, 21'h000041, 21'd0);

        // Boundary ranges after special leads
        send("e0", 8'hE0); send("80", 8'h80);
        check_outs("overlong_e0", 2, 21'h00FFFD, 21'h00FFFD, 21'd0);
        send("ed", 8'hED); send("a0", 8'hA0);
        check_outs("surrogate_ed", 2, 21'h00FFFD, 21'h00FFFD, 21'd0);
        send("f4", 8'hF4); send("90", 8'h90);
        check_outs("above_max_f4", 2, 21'h00FFFD, 21'h00FFFD, 21'd0);
        send("ed", 8'hED); send("9f", 8'h9F); send("bf", 8'hBF);
        check_outs("ed_max_ok", 1, 21'h00D7FF, 21'd0, 21'd0);
        send("f4", 8'hF4); send("8f", 8'h8F); send("bf", 8'hBF); send("bf", 8'hBF);
        check_outs("max_cp", 1, 21'h10FFFF, 21'd0, 21'd0);
        send("c0", 8'hC0); send("ff", 8'hFF);
        check_outs("bad_leads", 2, 21'h00FFFD, 21'h00FFFD, 21'd0);

        // Backpressure: first word held, input stalled, nothing lost
        bus.receiver_ready = 1'b0;
        send("bp41", 8'h41);
        bus.in_data           = 8'h42;
        bus.in_data_available = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_value%0d", i), bus.out_codepoint, 21'h000041);
            chk($sformatf("bp_hold_ready%0d", i), 21'(bus.in_data_ready), 21'd0);
            step();
        end
        bus.receiver_ready = 1'b1;
        send("bp42", 8'h42);
        send("bp43", 8'h43);
        check_outs("backpressure", 3, 21'h000041, 21'h000042, 21'h000043);

        // Reset mid-sequence discards the partial code point
        send("e2", 8'hE2); send("82", 8'h82);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_codepoint", bus.out_codepoint, 21'd0);
        chk("midrst_available", 21'(bus.out_available), 21'd0);
        step();
        reset = 1'b0;
        step();
        send("post_rst", 8'h41);
        check_outs("mid_reset", 1, 21'h000041, 21'd0, 21'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
